// File: rtl/clock_generator_pkg.sv
// Shared divisor arithmetic for the serial bit-rate clock dividers.
package clock_generator_pkg;

  // Nearest-integer divisor; a zero request yields 0 so elaboration can flag it cleanly.
  function automatic int unsigned divisor_round(input int unsigned clk_freq,
                                                input int unsigned freq);
    if (freq == 0) return 0;
    return (clk_freq + freq / 2) / freq;
  endfunction

endpackage

// File: rtl/clock_generator.sv
// Integer clock divider: registered, glitch-free ~50% square wave in the clk domain.
// The extra cycle of an odd divisor always goes to the low phase.
module clock_generator
  import clock_generator_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned FREQ     = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic new_clk
);

  localparam int unsigned N_RAW       = divisor_round(CLK_FREQ, FREQ);
  // Clamp keeps the widths sane while the illegal-parameter error is reported.
  localparam int unsigned N           = (N_RAW < 2) ? 2 : N_RAW;
  localparam int unsigned HIGH_CYCLES = N / 2;
  localparam int unsigned LOW_CYCLES  = N - HIGH_CYCLES;
  localparam int unsigned CW          = (LOW_CYCLES > 1) ? $clog2(LOW_CYCLES) : 1;

  localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES - 1);

  if (FREQ == 0) begin : g_bad_freq
    $error("clock_generator: FREQ must be > 0");
  end
  if (CLK_FREQ < 2 * FREQ) begin : g_bad_ratio
    $error("clock_generator: CLK_FREQ must be >= 2*FREQ");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] half_last;
  logic          new_clk_next;

  always_comb begin
    half_last    = new_clk ? HIGH_LAST : LOW_LAST;
    cnt_next     = cnt + CW'(1);
    new_clk_next = new_clk;
    if (cnt == half_last) begin
      cnt_next     = '0;
      new_clk_next = ~new_clk;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      new_clk <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      new_clk <= new_clk_next;
    end
  end

endmodule

// File: tb/tb_clock_generator.sv
// Directed bench for clock_generator: default divisor, N=5 and N=2 instances, async reset.
module tb_clock_generator;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic clk_def;
  logic clk_n5;
  logic clk_n2;

  int unsigned total = 0;
  int unsigned bad   = 0;

  clock_generator u_def (
    .clk    (clk),
    .reset  (reset),
    .new_clk(clk_def)
  );

  clock_generator #(.CLK_FREQ(10), .FREQ(2)) u_n5 (
    .clk    (clk),
    .reset  (reset),
    .new_clk(clk_n5)
  );

  clock_generator #(.CLK_FREQ(8), .FREQ(4)) u_n2 (
    .clk    (clk),
    .reset  (reset),
    .new_clk(clk_n2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    // Level after rising edge k (bit k-1): N=5 is low,low,high,high,low; N=2 alternates from high.
    logic [19:0] n5_pat;
    logic [19:0] n2_pat;
    logic        prev;
    logic        found;
    int unsigned last_edge;
    int unsigned ntrans;
    int unsigned n;

    n5_pat = 20'h6318C;
    n2_pat = 20'h55555;

    repeat (3) begin
      @(negedge clk);
      check("rst_def", clk_def, 0);
      check("rst_n5", clk_n5, 0);
      check("rst_n2", clk_n2, 0);
    end
    reset = 1'b1;

    prev      = 1'b0;
    last_edge = 0;
    ntrans    = 0;
    for (int unsigned k = 1; k <= 52085; k++) begin
      @(negedge clk);
      if (k <= 20) begin
        check($sformatf("n5_e%0d", k), clk_n5, n5_pat[k-1]);
        check($sformatf("n2_e%0d", k), clk_n2, n2_pat[k-1]);
      end
      if (clk_def !== prev) begin
        ntrans++;
        if (ntrans == 1) check("first_rise", k, 5209);
        if (ntrans == 2) check("first_fall", k, 10417);
        if (ntrans == 3) check("second_rise", k, 15626);
        if (clk_def === 1'b1) check($sformatf("low_len%0d", ntrans), k - last_edge, 5209);
        else                  check($sformatf("high_len%0d", ntrans), k - last_edge, 5208);
        last_edge = k;
        prev      = clk_def;
      end
    end
    check("trans_count", ntrans, 10);

    found = 1'b0;
    for (int unsigned k = 0; k < 6000 && !found; k++) begin
      @(negedge clk);
      if (clk_def === 1'b1) found = 1'b1;
    end
    check("wait_high", found, 1);

    repeat (2604) @(negedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_high", clk_def, 1);
    reset = 1'b0;
    #1;
    check("async_drop", clk_def, 0);
    repeat (2) begin
      @(negedge clk);
      check("held_def", clk_def, 0);
      check("held_n2", clk_n2, 0);
    end
    reset = 1'b1;

    n     = 0;
    found = 1'b0;
    while (n < 6000 && !found) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("rel_n2_e1", clk_n2, 1);
        check("rel_n5_e1", clk_n5, 0);
      end
      if (clk_def === 1'b1) found = 1'b1;
    end
    check("rise_after_reset", n, 5209);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_generator.md
# clock_generator

Integer clock divider that derives a slow, approximately 50 %-duty square wave `new_clk` from the system clock `clk`. It produces the bit-rate clock (default 9600 Hz) for the serial blocks (UART/SPI/I2C) from a 100 MHz system clock. The output is a registered, glitch-free signal in the `clk` domain. Consumers sample it or edge-detect it; it is not routed onto a clock tree.

## Interface
- `CLK_FREQ`, default 100_000_000: frequency of `clk` in Hz.
- `FREQ`, default 9600: requested `new_clk` frequency in Hz.
- `clk`  input  1  system clock; all logic is on its rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `new_clk`  output  1  divided clock, registered.

## Operation
- Divisor N = round(CLK_FREQ / FREQ), computed as (CLK_FREQ + FREQ/2) / FREQ in integer arithmetic at elaboration. Default: N = 10417.
- HIGH_CYCLES = N / 2 (floor). LOW_CYCLES = N − HIGH_CYCLES. Default: 5208 high, 5209 low.
- Counter `cnt` has width $clog2(LOW_CYCLES) (minimum 1) and is unsigned.
- While `reset` = 0, asynchronously force `cnt` = 0 and `new_clk` = 0.
- On each `clk` rising edge with `reset` = 1:
  - Current half-length L is LOW_CYCLES when `new_clk` = 0 and HIGH_CYCLES when `new_clk` = 1.
  - If `cnt` == L − 1: `cnt` ← 0 and `new_clk` ← ~`new_clk`.
  - Otherwise: `cnt` ← `cnt` + 1.
- `cnt` never exceeds LOW_CYCLES − 1, so no wrap-around can occur.
- Output period is exactly N `clk` cycles. The frequency error comes only from rounding N (default 9599.69 Hz, −0.003 %).
- Parameter legality is checked at elaboration with `$error`:
  - FREQ > 0;
  - CLK_FREQ ≥ 2·FREQ, so that N ≥ 2 and HIGH_CYCLES ≥ 1.
- Degenerate case N = 2: `new_clk` toggles on every `clk` edge (CLK_FREQ/2).
- Odd N: the extra cycle always goes to the low phase.
- Reset asserted mid-period: `new_clk` drops to 0 immediately (asynchronously) and the phase restarts from the beginning of a low phase.

## Timing
- Reset values: `new_clk` = 0, `cnt` = 0.
- After `reset` deasserts, the first rising edge of `clk` counts as cycle 1.
- `new_clk` rises at the LOW_CYCLES-th rising edge after reset release (5209 by default).
- `new_clk` then falls HIGH_CYCLES edges later, and the pattern repeats with period N.
- `new_clk` changes only on `clk` rising edges, apart from asynchronous reset assertion. It is glitch-free.
- Reset deassertion is not internally synchronized. Upstream provides a reset deasserted synchronously to `clk`.
- No handshake and no enable. The block free-runs whenever out of reset.

## Structure
- No shared package is required. N, HIGH_CYCLES, LOW_CYCLES and the counter width are localparams inside the module.
- If several serial blocks need the same divisor arithmetic, place a `divisor_round` constant function in `serial_pkg`.
- Single flat module. No sub-module.

## Test plan
- Default parameters, reset held at 0 for 3 cycles: `new_clk` = 0 throughout. After release, the first rise occurs at edge 5209, the first fall at edge 10417, and the next rise at edge 15626 (period 10417 cycles = 104.17 µs at 10 ns).
- CLK_FREQ = 10, FREQ = 2 (N = 5): waveform after reset is low 3 cycles, high 2 cycles, repeating. Check 4 periods.
- CLK_FREQ = 8, FREQ = 4 (N = 2): `new_clk` toggles every cycle, starting with a rise at edge 1.
- Assert reset asynchronously (mid-cycle) while `new_clk` = 1, halfway through a high phase: `new_clk` goes to 0 without waiting for a `clk` edge. After release, the full LOW_CYCLES low phase repeats before the next rise.
- Measure 100 consecutive periods with default parameters: every high phase is 5208 cycles and every low phase is 5209, with no deviation.
- FREQ = 0, or CLK_FREQ = 1 with FREQ = 1: elaboration fails with `$error`.
